spw_link_fsm_param: RTL and testbench
=====================================

// Module: spw_link_fsm_param
// PURPOSE
//  Parametrised SpaceWire link-initialisation FSM (ECSS-E-ST-50-12C 8.5): ErrorReset->ErrorWait->Ready->Started->Connecting->Run.
//  Sits between the RX decoder and the TX encoder in the SpW link core. Drives RX reset, TX enable and NULL/FCT sending.
//  Beyond the earlier link FSM: cycle-count timeouts as parameters, sticky gotNULL, error-cause capture and a saturating error counter.
// PARAMETERS
//  T_6P4US     640   cycles in 6.4 us (ErrorReset and ErrorWait dwell)
//  T_12P8US    1280  cycles in 12.8 us (ErrorWait exit; Started/Connecting timeout)
//  T_850NS     85    cycles in 850 ns (Run disconnect timeout)
//  TMR_W       12    timer width; must satisfy 2**TMR_W > T_12P8US
//  ERR_CNT_W   8     error counter width
// PORTS
//  pclk              in   1          system clock
//  reset             in   1          synchronous, active-high reset
//  auto_start        in   1          start on first received NULL
//  link_start        in   1          start immediately
//  link_disable      in   1          force exit from Run / block start
//  rx_error          in   1          RX disconnect/parity/escape error pulse
//  rx_credit_error   in   1          credit overflow pulse
//  rx_got_bit        in   1          any bit received this cycle
//  rx_got_null       in   1          NULL received pulse
//  rx_got_nchar      in   1          N-char received pulse
//  rx_got_time_code  in   1          time-code received pulse
//  rx_got_fct        in   1          FCT received pulse
//  err_cnt_clr       in   1          clear err_cnt
//  rx_resetn         out  1          0 only in ErrorReset
//  enable_tx         out  1          0 in ErrorReset/ErrorWait or while reset=1
//  send_null_tx      out  1          1 in Started/Connecting/Run
//  send_fct_tx       out  1          1 in Connecting/Run
//  link_up           out  1          1 in Run
//  fsm_state         out  3          0 ERR_RESET,1 ERR_WAIT,2 READY,3 STARTED,4 CONNECTING,5 RUN
//  err_cause         out  3          cause of most recent entry into ErrorReset
//  err_cnt           out  ERR_CNT_W  saturating count of ErrorReset entries
// BEHAVIOUR
//  Reset (reset=1 at pclk edge): state=ERR_RESET, timer=0, got_null_s=0, err_cause=0, err_cnt=0.
//   Outputs then: rx_resetn=0, enable_tx=0, send_null_tx=0, send_fct_tx=0, link_up=0.
//  All outputs decode combinationally from the state register. A transition takes effect 1 cycle after the qualifying input.
//  timer: clears on every state change; otherwise increments, saturating at T_12P8US.
//  got_null_s: set by rx_got_null in ERR_WAIT/READY/STARTED; cleared in ERR_RESET.
//  premature = rx_got_fct|rx_got_nchar|rx_got_time_code (rx_got_fct excluded in CONNECTING and RUN).
//  Transitions:
//   ERR_RESET : timer==T_6P4US-1 -> ERR_WAIT. Unconditional, independent of the start inputs.
//   ERR_WAIT  : rx_error|premature -> ERR_RESET; else timer==T_12P8US-1 -> READY.
//   READY     : rx_error|premature -> ERR_RESET; else !link_disable & (link_start | auto_start&got_null_s) -> STARTED.
//   STARTED   : rx_error|premature|timer==T_12P8US-1 -> ERR_RESET; else got_null_s -> CONNECTING.
//   CONNECTING: rx_error|premature|timer==T_12P8US-1 -> ERR_RESET; else rx_got_fct -> RUN.
//   RUN       : rx_error|rx_credit_error|link_disable|disc_to -> ERR_RESET.
//  disc_to: in RUN, count cycles since the last rx_got_bit (rx_got_bit clears the count). disc_to=1 when count reaches T_850NS-1.
//  err_cause: loaded on every transition into ERR_RESET from another state. Among simultaneous causes, the first in this list wins:
//   1 rx_error, 2 rx_credit_error, 3 premature char, 4 12.8 us timeout, 5 disconnect, 6 link_disable. Value 0 = none since reset.
//  err_cnt: +1 on each such transition; saturates at all-ones. err_cnt_clr wins over a same-cycle increment (result 0).
//  reset asserted mid-operation overrides all pending transitions; err_cnt and err_cause clear.
//  Undefined state codes (6, 7) -> ERR_RESET on the next cycle; err_cause and err_cnt unchanged.
// TESTING
//  Sim params T_6P4US=8, T_12P8US=16, T_850NS=5.
//  1 Reset release, link_start=1 -> ERR_WAIT at cycle 8; READY at 24; STARTED at 25; rx_resetn=0 only during cycles 0-7.
//  2 READY, auto_start=1, one rx_got_null pulse -> STARTED; no further NULL -> CONNECTING (sticky); rx_got_fct -> RUN, link_up=1.
//  3 In RUN, rx_got_bit held low -> ERR_RESET exactly 5 cycles later; err_cause=5, err_cnt=1.
//  4 In CONNECTING, no FCT for 16 cycles -> ERR_RESET, err_cause=4. rx_error and rx_got_nchar in the same cycle in READY -> err_cause=1.
//  5 Force 255 error entries with ERR_CNT_W=8 -> err_cnt stays 255; err_cnt_clr on the same cycle as an entry -> err_cnt=0.
//  6 reset pulsed for 1 cycle while in RUN -> next cycle ERR_RESET, enable_tx=0, err_cnt=0, err_cause=0.

Source files
------------

// File: rtl/spw_link_fsm_param.sv
// SpaceWire link-initialisation FSM with cycle-count timeouts,
// sticky gotNULL, error-cause capture and a saturating error counter.
module spw_link_fsm_param #(
   parameter int T_6P4US   = 640,
   parameter int T_12P8US  = 1280,
   parameter int T_850NS   = 85,
   parameter int TMR_W     = 12,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 pclk,
   input  logic                 reset,
   input  logic                 auto_start,
   input  logic                 link_start,
   input  logic                 link_disable,
   input  logic                 rx_error,
   input  logic                 rx_credit_error,
   input  logic                 rx_got_bit,
   input  logic                 rx_got_null,
   input  logic                 rx_got_nchar,
   input  logic                 rx_got_time_code,
   input  logic                 rx_got_fct,
   input  logic                 err_cnt_clr,
   output logic                 rx_resetn,
   output logic                 enable_tx,
   output logic                 send_null_tx,
   output logic                 send_fct_tx,
   output logic                 link_up,
   output logic [2:0]           fsm_state,
   output logic [2:0]           err_cause,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      ST_ERR_RESET  = 3'd0,
      ST_ERR_WAIT   = 3'd1,
      ST_READY      = 3'd2,
      ST_STARTED    = 3'd3,
      ST_CONNECTING = 3'd4,
      ST_RUN        = 3'd5
   } state_e;

   localparam logic [TMR_W-1:0] T_RST  = TMR_W'(T_6P4US - 1);
   localparam logic [TMR_W-1:0] T_TMO  = TMR_W'(T_12P8US - 1);
   localparam logic [TMR_W-1:0] T_SAT  = TMR_W'(T_12P8US);
   localparam logic [TMR_W-1:0] T_DISC = TMR_W'(T_850NS - 1);

   state_e               state_q, state_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [TMR_W-1:0]     dcnt_q, dcnt_d;
   logic                 gnull_q, gnull_d;
   logic [2:0]           cause_q, cause_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0] cause;
   logic       prem_all, prem_nofct, tmo, disc_to;

   assign prem_all   = rx_got_fct | rx_got_nchar | rx_got_time_code;
   assign prem_nofct = rx_got_nchar | rx_got_time_code;
   assign tmo        = (timer_q == T_TMO);
   assign disc_to    = (state_q == ST_RUN) && !rx_got_bit
                       && (dcnt_q == T_DISC);

   // cause != 0 forces ErrorReset; the if-chain order sets priority
   always_comb begin
      state_d = state_q;
      cause   = 3'd0;
      case (state_q)
         ST_ERR_RESET: begin
            if (timer_q == T_RST) state_d = ST_ERR_WAIT;
         end
         ST_ERR_WAIT: begin
            if (rx_error)      cause   = 3'd1;
            else if (prem_all) cause   = 3'd3;
            else if (tmo)      state_d = ST_READY;
         end
         ST_READY: begin
            if (rx_error)      cause   = 3'd1;
            else if (prem_all) cause   = 3'd3;
            else if (!link_disable &&
                     (link_start || (auto_start && gnull_q)))
               state_d = ST_STARTED;
         end
         ST_STARTED: begin
            if (rx_error)      cause   = 3'd1;
            else if (prem_all) cause   = 3'd3;
            else if (tmo)      cause   = 3'd4;
            else if (gnull_q)  state_d = ST_CONNECTING;
         end
         ST_CONNECTING: begin
            if (rx_error)        cause   = 3'd1;
            else if (prem_nofct) cause   = 3'd3;
            else if (tmo)        cause   = 3'd4;
            else if (rx_got_fct) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (rx_error)             cause = 3'd1;
            else if (rx_credit_error) cause = 3'd2;
            else if (disc_to)         cause = 3'd5;
            else if (link_disable)    cause = 3'd6;
         end
         default: state_d = ST_ERR_RESET;
      endcase
      if (cause != 3'd0) state_d = ST_ERR_RESET;
   end

   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q)  timer_d = '0;
      else if (timer_q != T_SAT) timer_d = timer_q + 1'b1;

      dcnt_d = dcnt_q;
      if (state_q != ST_RUN || rx_got_bit) dcnt_d = '0;
      else if (dcnt_q != T_DISC)           dcnt_d = dcnt_q + 1'b1;

      gnull_d = gnull_q;
      if (state_q == ST_ERR_RESET) gnull_d = 1'b0;
      else if (rx_got_null && (state_q == ST_ERR_WAIT ||
               state_q == ST_READY || state_q == ST_STARTED))
         gnull_d = 1'b1;

      cause_d = cause_q;
      cnt_d   = cnt_q;
      if (cause != 3'd0) begin
         cause_d = cause;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      if (err_cnt_clr) cnt_d = '0;
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q <= ST_ERR_RESET;
         timer_q <= '0;
         dcnt_q  <= '0;
         gnull_q <= 1'b0;
         cause_q <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         dcnt_q  <= dcnt_d;
         gnull_q <= gnull_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      rx_resetn    = (state_q != ST_ERR_RESET);
      enable_tx    = !reset && (state_q == ST_READY ||
                     state_q == ST_STARTED ||
                     state_q == ST_CONNECTING || state_q == ST_RUN);
      send_null_tx = (state_q == ST_STARTED) ||
                     (state_q == ST_CONNECTING) || (state_q == ST_RUN);
      send_fct_tx  = (state_q == ST_CONNECTING) || (state_q == ST_RUN);
      link_up      = (state_q == ST_RUN);
   end

   assign fsm_state = state_q;
   assign err_cause = cause_q;
   assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_spw_link_fsm_param.sv
// Directed table-driven bench for spw_link_fsm_param
// using short timeouts (8/16/5 cycles).
module tb_spw_link_fsm_param;

   localparam logic [9:0] AS   = 10'b1000000000;
   localparam logic [9:0] LS   = 10'b0100000000;
   localparam logic [9:0] LD   = 10'b0010000000;
   localparam logic [9:0] ERR  = 10'b0001000000;
   localparam logic [9:0] CERR = 10'b0000100000;
   localparam logic [9:0] BIT  = 10'b0000010000;
   localparam logic [9:0] NUL  = 10'b0000001000;
   localparam logic [9:0] NCH  = 10'b0000000100;
   localparam logic [9:0] TC   = 10'b0000000010;
   localparam logic [9:0] FCT  = 10'b0000000001;
   localparam logic [9:0] NONE = 10'b0000000000;

   typedef struct {
      logic [9:0] in;
      int         n;
      logic [2:0] st;
      logic [2:0] cause;
      logic [7:0] cnt;
   } vec_t;

   logic       pclk = 1'b0;
   logic       reset;
   logic       auto_start, link_start, link_disable;
   logic       rx_error, rx_credit_error, rx_got_bit;
   logic       rx_got_null, rx_got_nchar, rx_got_time_code;
   logic       rx_got_fct, err_cnt_clr;
   logic       rx_resetn, enable_tx, send_null_tx;
   logic       send_fct_tx, link_up;
   logic [2:0] fsm_state, err_cause;
   logic [7:0] err_cnt;

   int   n_pass = 0;
   int   n_tot  = 0;
   vec_t tbl[$];

   spw_link_fsm_param #(
      .T_6P4US(8), .T_12P8US(16), .T_850NS(5),
      .TMR_W(12), .ERR_CNT_W(8)
   ) dut (
      .pclk(pclk), .reset(reset),
      .auto_start(auto_start), .link_start(link_start),
      .link_disable(link_disable), .rx_error(rx_error),
      .rx_credit_error(rx_credit_error),
      .rx_got_bit(rx_got_bit), .rx_got_null(rx_got_null),
      .rx_got_nchar(rx_got_nchar),
      .rx_got_time_code(rx_got_time_code),
      .rx_got_fct(rx_got_fct), .err_cnt_clr(err_cnt_clr),
      .rx_resetn(rx_resetn), .enable_tx(enable_tx),
      .send_null_tx(send_null_tx), .send_fct_tx(send_fct_tx),
      .link_up(link_up), .fsm_state(fsm_state),
      .err_cause(err_cause), .err_cnt(err_cnt)
   );

   always #5 pclk = ~pclk;

   // {rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_up}
   function automatic logic [4:0] exp_out(input logic [2:0] st);
      return {st != 3'd0, st >= 3'd2, st >= 3'd3,
              st >= 3'd4, st == 3'd5};
   endfunction

   function automatic void add(input logic [9:0] in, input int n,
                               input logic [2:0] st, input logic [2:0] c,
                               input logic [7:0] k);
      vec_t v;
      v.in = in; v.n = n; v.st = st; v.cause = c; v.cnt = k;
      tbl.push_back(v);
   endfunction

   task automatic check(input string nm, input int idx,
                        input logic [7:0] act, input logic [7:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s step %0d: got %0h want %0h",
                  nm, idx, act, exp);
      else
         n_pass++;
   endtask

   task automatic apply(input vec_t v, input int idx);
      {auto_start, link_start, link_disable, rx_error,
       rx_credit_error, rx_got_bit, rx_got_null, rx_got_nchar,
       rx_got_time_code, rx_got_fct} = v.in;
      if (v.n > 0) begin
         repeat (v.n) @(posedge pclk);
         @(negedge pclk);
      end else begin
         #1;
      end
      check("state", idx, 8'(fsm_state), 8'(v.st));
      check("outs", idx,
            8'({rx_resetn, enable_tx, send_null_tx,
                send_fct_tx, link_up}), 8'(exp_out(v.st)));
      check("cause", idx, 8'(err_cause), 8'(v.cause));
      check("cnt", idx, err_cnt, v.cnt);
   endtask

   task automatic step(input logic [9:0] in, input int n,
                       input logic [2:0] st, input logic [2:0] c,
                       input logic [7:0] k, input int idx);
      vec_t v;
      v.in = in; v.n = n; v.st = st; v.cause = c; v.cnt = k;
      apply(v, idx);
   endtask

   initial begin
      // bring-up, STARTED timeout, auto-start, RUN disconnect
      add(LS,        0, 0, 0, 0);
      add(LS,        7, 0, 0, 0);
      add(LS,        1, 1, 0, 0);
      add(LS,       15, 1, 0, 0);
      add(LS,        1, 2, 0, 0);
      add(LS,        1, 3, 0, 0);
      add(LS,       15, 3, 0, 0);
      add(LS,        1, 0, 4, 1);
      add(AS,        8, 1, 4, 1);
      add(AS,       16, 2, 4, 1);
      add(AS,        3, 2, 4, 1);
      add(AS | NUL,  1, 2, 4, 1);
      add(AS,        1, 3, 4, 1);
      add(AS,        1, 4, 4, 1);
      add(AS | FCT,  1, 5, 4, 1);
      add(AS,        4, 5, 4, 1);
      add(AS,        1, 0, 5, 2);
      // RUN kept alive by bits, then credit error beats disable
      add(LS | NUL,  8, 1, 5, 2);
      add(LS | NUL, 16, 2, 5, 2);
      add(LS | NUL,  1, 3, 5, 2);
      add(LS | NUL,  1, 4, 5, 2);
      add(LS | FCT,  1, 5, 5, 2);
      add(BIT,      10, 5, 5, 2);
      add(BIT | CERR | LD, 1, 0, 2, 3);
      // premature FCT in ERR_WAIT, disable blocks start
      add(NONE,      8, 1, 2, 3);
      add(FCT,       1, 0, 3, 4);
      add(NONE,      8, 1, 3, 4);
      add(NONE,     16, 2, 3, 4);
      add(LD | LS,   2, 2, 3, 4);
      // CONNECTING timeout
      add(LS,        1, 3, 3, 4);
      add(NUL,       1, 3, 3, 4);
      add(NONE,      1, 4, 3, 4);
      add(NONE,     15, 4, 3, 4);
      add(NONE,      1, 0, 4, 5);
      // rx_error beats premature in READY
      add(NONE,      8, 1, 4, 5);
      add(NONE,     16, 2, 4, 5);
      add(ERR | NCH, 1, 0, 1, 6);
      // chars in RUN are harmless, link_disable exits
      add(NONE,      8, 1, 1, 6);
      add(NONE,     16, 2, 1, 6);
      add(LS,        1, 3, 1, 6);
      add(NUL,       1, 3, 1, 6);
      add(NONE,      1, 4, 1, 6);
      add(FCT,       1, 5, 1, 6);
      add(BIT | FCT | NCH | TC, 3, 5, 1, 6);
      add(BIT | LD,  1, 0, 6, 7);

      reset = 1'b1;
      err_cnt_clr = 1'b0;
      {auto_start, link_start, link_disable, rx_error,
       rx_credit_error, rx_got_bit, rx_got_null, rx_got_nchar,
       rx_got_time_code, rx_got_fct} = NONE;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_state", 0, 8'(fsm_state), 8'd0);
      check("rst_outs", 0,
            8'({rx_resetn, enable_tx, send_null_tx,
                send_fct_tx, link_up}), 8'd0);
      check("rst_cause", 0, 8'(err_cause), 8'd0);
      check("rst_cnt", 0, err_cnt, 8'd0);
      reset = 1'b0;

      foreach (tbl[i]) apply(tbl[i], i);

      // reset pulse while in RUN
      step(NONE,     8, 1, 6, 7, 100);
      step(NONE,    16, 2, 6, 7, 101);
      step(LS | NUL, 1, 3, 6, 7, 102);
      step(NONE,     1, 4, 6, 7, 103);
      step(FCT,      1, 5, 6, 7, 104);
      step(BIT,      1, 5, 6, 7, 105);
      reset = 1'b1;
      #1;
      check("rst_run_state", 106, 8'(fsm_state), 8'd5);
      check("rst_run_entx", 106, 8'(enable_tx), 8'd0);
      @(posedge pclk);
      @(negedge pclk);
      reset = 1'b0;
      step(NONE,     0, 0, 0, 0, 107);

      // counter saturation and clear-wins collision
      step(ERR, 9 * 254, 0, 1, 254, 200);
      step(ERR,      9, 0, 1, 255, 201);
      step(ERR,     27, 0, 1, 255, 202);
      step(ERR,      8, 1, 1, 255, 203);
      err_cnt_clr = 1'b1;
      step(ERR,      1, 0, 1, 0, 204);
      err_cnt_clr = 1'b0;
      step(ERR,      9, 0, 1, 1, 205);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
